// File: rtl/rollo_ct_receiver.sv
// ROLLO ciphertext receiver: buffers one frame of NUM_WORDS words from a
// valid/ready stream, pulses dec_start, serves decrypt-core reads and waits
// for dec_done before accepting the next frame.
// Ports: clk, rst_b (async, active-high); in_valid/in_sof/in_data/in_ready
// upstream port; dec_start/dec_done/busy decrypt handshake; rd_addr/rd_data
// registered buffer read port; err_sof error pulse; frame_cnt frames launched.
module rollo_ct_receiver #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 96,
   parameter int ADDR_W    = 7
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              in_valid,
   input  logic              in_sof,
   input  logic [WORD_W-1:0] in_data,
   output logic              in_ready,
   output logic              dec_start,
   input  logic              dec_done,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data,
   output logic              busy,
   output logic              err_sof,
   output logic [15:0]       frame_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      LAUNCH,
      BUSY
   } state_t;

   localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NUM_WORDS - 1);

   state_t            state;
   logic [ADDR_W:0]   count;
   logic [WORD_W-1:0] mem [NUM_WORDS];

   logic              accept;
   logic              wr_en;
   logic              last_word;
   logic [ADDR_W-1:0] wr_addr;

   assign accept    = in_valid & in_ready;
   // A non-sof word in IDLE is dropped and never touches the buffer.
   assign wr_en     = accept & (in_sof | (state == RECV));
   assign wr_addr   = in_sof ? '0 : count[ADDR_W-1:0];
   assign last_word = accept & ~in_sof & (state == RECV) & (count == LAST);

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= in_data;
   end

   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         state     <= IDLE;
         count     <= '0;
         in_ready  <= 1'b0;
         dec_start <= 1'b0;
         busy      <= 1'b0;
         err_sof   <= 1'b0;
         frame_cnt <= '0;
         rd_data   <= '0;
      end else begin
         rd_data   <= mem[rd_addr];
         dec_start <= 1'b0;
         err_sof   <= 1'b0;
         case (state)
            IDLE: begin
               // Also raises in_ready on the first clock after reset.
               in_ready <= 1'b1;
               if (accept) begin
                  if (in_sof) begin
                     count <= ONE;
                     state <= RECV;
                  end else begin
                     err_sof <= 1'b1;
                  end
               end
            end
            RECV: begin
               if (accept) begin
                  if (in_sof) begin
                     count   <= ONE;
                     err_sof <= 1'b1;
                  end else if (last_word) begin
                     // in_ready drops with the launch so no word is lost.
                     count     <= count + ONE;
                     state     <= LAUNCH;
                     in_ready  <= 1'b0;
                     dec_start <= 1'b1;
                     busy      <= 1'b1;
                     frame_cnt <= frame_cnt + 16'd1;
                  end else begin
                     count <= count + ONE;
                  end
               end
            end
            LAUNCH: begin
               // dec_done here is ignored on purpose.
               state <= BUSY;
            end
            BUSY: begin
               if (dec_done) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  in_ready <= 1'b1;
                  count    <= '0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
